// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer:
// FSM state encodings and default phase durations.
package wm_pkg;

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_FILLING_WATER = 3'd1;
  localparam logic [2:0] S_WASHING       = 3'd2;
  localparam logic [2:0] S_RINSING       = 3'd3;
  localparam logic [2:0] S_SPINNING      = 3'd4;

  localparam int DEF_TICK_DIV  = 1_000_000;
  localparam int DEF_FILL_SEC  = 60;
  localparam int DEF_WASH_SEC  = 300;
  localparam int DEF_RINSE_SEC = 120;
  localparam int DEF_SPIN_SEC  = 60;
  localparam int DEF_SEC_W     = 9;

endpackage

// File: rtl/wm_tick_gen.sv
// One-second prescaler: counts enabled cycles and emits a one-cycle tick every
// TICK_DIV of them; holds its partial count while disabled.
module wm_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             at_last;

  assign at_last = (pre == PRE_LAST);
  // clear wins over enable so a new phase always starts from a whole second
  assign tick    = enable && !clear && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      if (at_last) pre <= '0;
      else         pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer: reloads the phase duration whenever the FSM state changes,
// counts it down in one-second ticks and pulses state_done on expiry.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int FILL_SEC  = DEF_FILL_SEC,
  parameter int WASH_SEC  = DEF_WASH_SEC,
  parameter int RINSE_SEC = DEF_RINSE_SEC,
  parameter int SPIN_SEC  = DEF_SPIN_SEC,
  parameter int SEC_W     = DEF_SEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       state,
  input  logic             timer_pause,
  output logic             state_done,
  output logic [SEC_W-1:0] sec_left
);

  logic [2:0]       prev_state;
  logic             done_flag;
  logic             load;
  logic             paused;
  logic             active;
  logic             tick;
  logic [SEC_W-1:0] load_val;

  assign load   = (state != prev_state);
  assign paused = timer_pause && (state == S_SPINNING);
  assign active = (sec_left != '0) && !load && !paused;

  always_comb begin
    load_val = '0;
    case (state)
      S_FILLING_WATER: load_val = SEC_W'(FILL_SEC);
      S_WASHING:       load_val = SEC_W'(WASH_SEC);
      S_RINSING:       load_val = SEC_W'(RINSE_SEC);
      S_SPINNING:      load_val = SEC_W'(SPIN_SEC);
      default:         load_val = '0;
    endcase
  end

  wm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load),
    .enable(active),
    .tick  (tick)
  );

  // IDLE/invalid phases load 0, so they never tick and never pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_state <= S_IDLE;
      sec_left   <= '0;
      done_flag  <= 1'b0;
      state_done <= 1'b0;
    end else begin
      state_done <= 1'b0;
      if (load) begin
        prev_state <= state;
        sec_left   <= load_val;
        done_flag  <= 1'b0;
      end else if (tick) begin
        sec_left <= sec_left - SEC_W'(1);
        if (sec_left == SEC_W'(1) && !done_flag) begin
          state_done <= 1'b1;
          done_flag  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wm_phase_timer.sv
// Table-driven bench for wm_phase_timer with short durations (TICK_DIV=4,
// FILL=3, WASH=5, RINSE=2, SPIN=3); each row is one clock edge.
module tb_wm_phase_timer;

  localparam int SEC_W = 9;

  typedef struct {
    logic             rst_n;
    logic [2:0]       state;
    logic             pause;
    logic             exp_done;
    logic [SEC_W-1:0] exp_sec;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       state;
  logic             timer_pause;
  logic             state_done;
  logic [SEC_W-1:0] sec_left;

  vec_t vec_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  wm_phase_timer #(
    .TICK_DIV (4),
    .FILL_SEC (3),
    .WASH_SEC (5),
    .RINSE_SEC(2),
    .SPIN_SEC (3),
    .SEC_W    (SEC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .timer_pause(timer_pause),
    .state_done (state_done),
    .sec_left   (sec_left)
  );

  task automatic add(input logic r, input logic [2:0] s, input logic p,
                     input logic d, input int sec, input int n);
    vec_t v;
    v.rst_n = r; v.state = s; v.pause = p; v.exp_done = d;
    v.exp_sec = SEC_W'(sec);
    for (int i = 0; i < n; i++) vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic got_d, input logic [SEC_W-1:0] got_s,
                       input logic exp_d, input logic [SEC_W-1:0] exp_s);
    n_vec++;
    if (got_d !== exp_d || got_s !== exp_s) begin
      n_miss++;
      $display("FAIL %s: got done=%b sec=%0d, expected done=%b sec=%0d",
               name, got_d, got_s, exp_d, exp_s);
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; state = 3'd0; timer_pause = 1'b0;

    // reset, then FILL (3 s) and hold after expiry
    add(0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 3, 4);
    add(1, 1, 0, 0, 2, 4);
    add(1, 1, 0, 0, 1, 4);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 20);
    // SPIN with 7 paused cycles: done at E0+19
    add(1, 4, 0, 0, 3, 4);
    add(1, 4, 0, 0, 2, 1);
    add(1, 4, 1, 0, 2, 7);
    add(1, 4, 0, 0, 2, 3);
    add(1, 4, 0, 0, 1, 4);
    add(1, 4, 0, 1, 0, 1);
    add(1, 4, 0, 0, 0, 2);
    // WASH with the same pause ignored: done at E0+20
    add(1, 2, 0, 0, 5, 4);
    add(1, 2, 0, 0, 4, 1);
    add(1, 2, 1, 0, 4, 3);
    add(1, 2, 1, 0, 3, 4);
    add(1, 2, 0, 0, 2, 4);
    add(1, 2, 0, 0, 1, 4);
    add(1, 2, 0, 1, 0, 1);
    add(1, 2, 0, 0, 0, 1);
    // double wash: RINSE, WASH, RINSE, each change on the done edge
    add(1, 3, 0, 0, 2, 4);
    add(1, 3, 0, 0, 1, 4);
    add(1, 3, 0, 1, 0, 1);
    add(1, 2, 0, 0, 5, 4);
    add(1, 2, 0, 0, 4, 4);
    add(1, 2, 0, 0, 3, 4);
    add(1, 2, 0, 0, 2, 4);
    add(1, 2, 0, 0, 1, 4);
    add(1, 2, 0, 1, 0, 1);
    add(1, 3, 0, 0, 2, 4);
    add(1, 3, 0, 0, 1, 4);
    add(1, 3, 0, 1, 0, 1);
    add(1, 3, 0, 0, 0, 2);
    // reset at E6 of WASH, full reload on release
    add(1, 2, 0, 0, 5, 4);
    add(1, 2, 0, 0, 4, 2);
    add(0, 2, 0, 0, 0, 1);
    add(1, 2, 0, 0, 5, 4);
    add(1, 2, 0, 0, 4, 4);
    add(1, 2, 0, 0, 3, 4);
    add(1, 2, 0, 0, 2, 4);
    add(1, 2, 0, 0, 1, 4);
    add(1, 2, 0, 1, 0, 1);
    add(1, 2, 0, 0, 0, 1);
    // invalid and IDLE never count or pulse
    add(1, 6, 1, 0, 0, 50);
    add(1, 0, 0, 0, 0, 50);
    add(1, 1, 0, 0, 3, 2);

    foreach (vec_q[i]) begin
      @(negedge clk);
      rst_n = vec_q[i].rst_n;
      state = vec_q[i].state;
      timer_pause = vec_q[i].pause;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), state_done, sec_left,
            vec_q[i].exp_done, vec_q[i].exp_sec);
    end

    // invalid encoding 5 loads 0, then SPIN mid-FILL reloads and expires in 12 cycles
    @(negedge clk); state = 3'd5;
    @(posedge clk); #1;
    check("invalid5_load", state_done, sec_left, 1'b0, '0);
    @(negedge clk); state = 3'd4;
    @(posedge clk); #1;
    check("spin_load", state_done, sec_left, 1'b0, SEC_W'(3));
    cnt = 0;
    while (!state_done && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_vec++;
    if (cnt != 12) begin
      n_miss++;
      $display("FAIL spin_latency: got %0d cycles, expected 12", cnt);
    end
    @(posedge clk); #1;
    check("spin_pulse_end", state_done, sec_left, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
